// File: rtl/wb_arb_sched_pkg.sv
// wb_arb_sched_pkg: shared sizes and FSM state encoding for the grant scheduler.
// The ABORT state exists only when WB_ARB_WATCHDOG_EN is defined.
package wb_arb_sched_pkg;
   localparam int N_MASTER = 4;
   localparam int IDX_W = 2;
`ifdef WB_ARB_WATCHDOG_EN
   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_ABORT} state_e;
`else
   typedef enum logic {ST_IDLE, ST_GRANT} state_e;
`endif
endpackage

// File: rtl/wb_arb_sched_if.sv
// wb_arb_sched_if: request/bus inputs and grant outputs of the scheduler.
// slave is the scheduler side, master is the interconnect side.
interface wb_arb_sched_if;
   import wb_arb_sched_pkg::*;
   logic [N_MASTER-1:0] req_i;
   logic                bus_stb_i;
   logic                bus_ack_i;
   logic [N_MASTER-1:0] grant_o;
   logic [IDX_W-1:0]    grant_idx_o;
   logic                grant_vld_o;
   logic                err_o;
   logic                kill_o;
   modport slave (input req_i, bus_stb_i, bus_ack_i,
                  output grant_o, grant_idx_o, grant_vld_o, err_o, kill_o);
   modport master (output req_i, bus_stb_i, bus_ack_i,
                   input grant_o, grant_idx_o, grant_vld_o, err_o, kill_o);
endinterface

// File: rtl/wb_arb_sched_rr_pick.sv
// wb_arb_sched_rr_pick: combinational round-robin picker, searching from last+1 around to last.
module wb_arb_sched_rr_pick
   import wb_arb_sched_pkg::*;
(
   input  logic [N_MASTER-1:0] req_i,
   input  logic [IDX_W-1:0]    last_i,
   output logic [N_MASTER-1:0] onehot_o,
   output logic [IDX_W-1:0]    idx_o,
   output logic                any_o
);
   always_comb begin
      idx_o = '0;
      // walk the search order backwards so the earliest requester overwrites the rest
      for (int i = N_MASTER; i >= 1; i--)
         if (req_i[IDX_W'(int'(last_i) + i)]) idx_o = IDX_W'(int'(last_i) + i);
      any_o = |req_i;
      onehot_o = any_o ? N_MASTER'(1) << idx_o : '0;
   end
endmodule

// File: rtl/wb_arb_sched.sv
// wb_arb_sched: round-robin Wishbone grant scheduler holding the grant for the whole cycle.
// Define WB_ARB_WATCHDOG_EN to add the stb-without-ack watchdog (ABORT state, err_o, kill_o).
module wb_arb_sched
   import wb_arb_sched_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int CNT_W = 16
) (
   input logic         wb_clk,
   input logic         wb_rst,
   wb_arb_sched_if.slave bus
);
   state_e              st_q, st_d;
   logic [N_MASTER-1:0] grant_q, grant_d, pick_oh;
   logic [IDX_W-1:0]    last_q, last_d, pick_idx;
   logic                pick_any, arb;
   if (TIMEOUT < 2 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_param
      $error("wb_arb_sched: TIMEOUT must be >= 2 and < 2**CNT_W");
   end
   wb_arb_sched_rr_pick u_pick (
      .req_i(bus.req_i), .last_i(last_q), .onehot_o(pick_oh), .idx_o(pick_idx), .any_o(pick_any)
   );
   assign arb = (st_q == ST_IDLE) || !bus.req_i[last_q];
   assign bus.grant_o = grant_q;
   assign bus.grant_vld_o = |grant_q;
   assign bus.grant_idx_o = bus.grant_vld_o ? last_q : '0;
`ifdef WB_ARB_WATCHDOG_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d, kill_q, kill_d;
   assign bus.err_o = err_q;
   assign bus.kill_o = kill_q;
   always_comb begin
      st_d = st_q;
      grant_d = grant_q;
      last_d = last_q;
      err_d = 1'b0;
      kill_d = kill_q;
      cnt_d = (st_q != ST_GRANT || bus.bus_ack_i) ? '0 : cnt_q;
      if (arb) begin
         st_d = pick_any ? ST_GRANT : ST_IDLE;
         grant_d = pick_oh;
         last_d = pick_any ? pick_idx : last_q;
         kill_d = 1'b0;
         cnt_d = '0;
      end else if (st_q == ST_GRANT && bus.bus_stb_i && !bus.bus_ack_i) begin
         if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d = 1'b1;
            kill_d = 1'b1;
            st_d = ST_ABORT;
         end else cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
   end
   always_ff @(posedge wb_clk or posedge wb_rst)
      if (wb_rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
         kill_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
         kill_q <= kill_d;
      end
`else
   assign bus.err_o = 1'b0;
   assign bus.kill_o = 1'b0;
   always_comb begin
      st_d = st_q;
      grant_d = grant_q;
      last_d = last_q;
      if (arb) begin
         st_d = pick_any ? ST_GRANT : ST_IDLE;
         grant_d = pick_oh;
         last_d = pick_any ? pick_idx : last_q;
      end
   end
`endif
   // pointer resets to the last master so master 0 wins the first search
   always_ff @(posedge wb_clk or posedge wb_rst)
      if (wb_rst) begin
         st_q <= ST_IDLE;
         grant_q <= '0;
         last_q <= IDX_W'(N_MASTER - 1);
      end else begin
         st_q <= st_d;
         grant_q <= grant_d;
         last_q <= last_d;
      end
endmodule

// File: tb/tb_wb_arb_sched.sv
// tb_wb_arb_sched: directed checks of grant order, hold, handoff, async reset and the watchdog.
// Watchdog checks follow WB_ARB_WATCHDOG_EN; without it the stuck-stb case expects no error.
module tb_wb_arb_sched;
   logic wb_clk = 1'b0;
   logic wb_rst = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic seen;
   wb_arb_sched_if bus ();
   wb_arb_sched #(.TIMEOUT(8), .CNT_W(16)) dut (.wb_clk(wb_clk), .wb_rst(wb_rst), .bus(bus.slave));
   always #5 wb_clk = ~wb_clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input int n = 1);
      repeat (n) @(posedge wb_clk);
      #1;
   endtask
   task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] idx);
      check({tag, "_grant"}, 32'(bus.grant_o), 32'(g));
      check({tag, "_vld"}, 32'(bus.grant_vld_o), 32'(|g));
      if (g != 4'b0) check({tag, "_idx"}, 32'(bus.grant_idx_o), 32'(idx));
   endtask
   task automatic pulse_reset();
      #2 wb_rst = 1'b1;
      #2 wb_rst = 1'b0;
   endtask
   initial begin
      bus.req_i = 4'b0;
      bus.bus_stb_i = 1'b0;
      bus.bus_ack_i = 1'b0;
      #1 wb_rst = 1'b1;
      #2;
      chk_grant("rst", 4'b0000, 2'd0);
      check("rst_idx", 32'(bus.grant_idx_o), 0);
      check("rst_err", 32'(bus.err_o), 0);
      check("rst_kill", 32'(bus.kill_o), 0);
      #9 wb_rst = 1'b0;
      bus.req_i = 4'b0001;
      step();
      chk_grant("t1_on", 4'b0001, 2'd0);
      bus.req_i = 4'b0000;
      step();
      chk_grant("t1_off", 4'b0000, 2'd0);
      pulse_reset();
      bus.req_i = 4'b0111;
      step();
      chk_grant("t2_m0", 4'b0001, 2'd0);
      step();
      chk_grant("t2_m0_hold", 4'b0001, 2'd0);
      bus.req_i = 4'b0110;
      step();
      chk_grant("t2_m1", 4'b0010, 2'd1);
      bus.req_i = 4'b0100;
      step();
      chk_grant("t2_m2", 4'b0100, 2'd2);
      bus.req_i = 4'b0000;
      step();
      chk_grant("t2_idle", 4'b0000, 2'd0);
      bus.req_i = 4'b0001;
      step();
      chk_grant("t3_m0", 4'b0001, 2'd0);
      bus.req_i = 4'b0111;
      step(3);
      chk_grant("t3_hold", 4'b0001, 2'd0);
      bus.req_i = 4'b0110;
      step();
      chk_grant("t3_m1", 4'b0010, 2'd1);
      bus.req_i = 4'b1101;
      step();
      chk_grant("rr_m2", 4'b0100, 2'd2);
      bus.req_i = 4'b1001;
      step();
      chk_grant("rr_m3", 4'b1000, 2'd3);
      bus.req_i = 4'b0011;
      step();
      chk_grant("rr_wrap", 4'b0001, 2'd0);
      bus.req_i = 4'b0000;
      step();
      bus.req_i = 4'b0001;
      step();
      chk_grant("regrant_a", 4'b0001, 2'd0);
      bus.req_i = 4'b0000;
      step();
      chk_grant("regrant_gap", 4'b0000, 2'd0);
      bus.req_i = 4'b0001;
      step();
      chk_grant("regrant_b", 4'b0001, 2'd0);
      #3 wb_rst = 1'b1;
      #1;
      chk_grant("t5_async", 4'b0000, 2'd0);
      check("t5_err", 32'(bus.err_o), 0);
      check("t5_kill", 32'(bus.kill_o), 0);
      #1 wb_rst = 1'b0;
      bus.req_i = 4'b1000;
      step();
      chk_grant("t5_m3", 4'b1000, 2'd3);
      bus.req_i = 4'b0000;
      step();
`ifdef WB_ARB_WATCHDOG_EN
      pulse_reset();
      bus.req_i = 4'b0001;
      step();
      bus.bus_stb_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         seen |= bus.err_o | bus.kill_o;
      end
      check("wd_early", 32'(seen), 0);
      step();
      check("wd_err", 32'(bus.err_o), 1);
      check("wd_kill", 32'(bus.kill_o), 1);
      step();
      check("wd_err_pulse", 32'(bus.err_o), 0);
      check("wd_kill_hold", 32'(bus.kill_o), 1);
      chk_grant("wd_abort", 4'b0001, 2'd0);
      bus.req_i = 4'b0000;
      bus.bus_stb_i = 1'b0;
      step();
      check("wd_kill_clr", 32'(bus.kill_o), 0);
      chk_grant("wd_release", 4'b0000, 2'd0);
      bus.req_i = 4'b0001;
      step();
      bus.bus_stb_i = 1'b1;
      step(7);
      bus.bus_ack_i = 1'b1;
      step();
      check("wd_ack_err", 32'(bus.err_o), 0);
      bus.bus_ack_i = 1'b0;
      step();
      check("wd_ack_kill", 32'(bus.kill_o), 0);
      bus.req_i = 4'b0000;
      bus.bus_stb_i = 1'b0;
      step();
      bus.req_i = 4'b0001;
      step();
      bus.bus_stb_i = 1'b1;
      step(7);
      bus.req_i = 4'b0000;
      step();
      check("wd_rel_err", 32'(bus.err_o), 0);
      check("wd_rel_kill", 32'(bus.kill_o), 0);
      chk_grant("wd_rel", 4'b0000, 2'd0);
      bus.bus_stb_i = 1'b0;
`else
      bus.req_i = 4'b0010;
      step();
      chk_grant("nowd_grant", 4'b0010, 2'd1);
      bus.bus_stb_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         step();
         seen |= bus.err_o | bus.kill_o | (bus.grant_o != 4'b0010);
      end
      check("nowd_stuck", 32'(seen), 0);
      bus.bus_stb_i = 1'b0;
      bus.req_i = 4'b0000;
      step();
      chk_grant("nowd_idle", 4'b0000, 2'd0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
